// File: rtl/uart_pkg.sv
// Shared parity-mode constants, FSM state types and the baud divider helper
// for the parametrised UART transceiver.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} txState_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rxState_e;

   // Rounded clocks-per-tick, never less than one so the tick always fires.
   function automatic int calcDiv(input longint clkHz, input longint baud, input longint ovs);
      longint den;
      longint q;
      den = baud * ovs;
      q   = (clkHz + den / 2) / den;
      if (q < 1) q = 1;
      return int'(q);
   endfunction

endpackage

// File: rtl/uart_xcvr_param_if.sv
// Handshake bundle between the UART transceiver (slave) and its control logic (master).
interface uart_xcvr_param_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] TX_DATA;
   logic                 TX_VALID;
   logic                 TX_READY;
   logic [DATA_BITS-1:0] RX_DATA;
   logic                 RX_VALID;
   logic                 RX_READY;
   logic                 RX_PERR;
   logic                 RX_FERR;
   logic                 RX_OVR;

   modport master (
      output TX_DATA, TX_VALID, RX_READY,
      input  TX_READY, RX_DATA, RX_VALID, RX_PERR, RX_FERR, RX_OVR
   );

   modport slave (
      input  TX_DATA, TX_VALID, RX_READY,
      output TX_READY, RX_DATA, RX_VALID, RX_PERR, RX_FERR, RX_OVR
   );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running divider producing the one-cycle oversampling tick shared by RX and TX.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 9600,
   parameter int OVERSAMPLE = 16
) (
   input  logic CLK,
   input  logic ARST_L,
   output logic TICK
);

   localparam int DIV = calcDiv(longint'(CLK_HZ), longint'(BAUD), longint'(OVERSAMPLE));
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) cnt_d = '0;
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign TICK = (cnt_q == LAST);

endmodule

// File: rtl/uart_xcvr_param.sv
// Full-duplex UART with configurable width/parity/stop bits, valid/ready handshakes
// and parity, framing and overrun reporting, all on a single system clock.
module uart_xcvr_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = 16
) (
   input  logic CLK,
   input  logic ARST_L,
   input  logic RX,
   output logic TX,
   uart_xcvr_param_if.slave bus
);

   localparam int BCW = $clog2(DATA_BITS + 1);
   localparam int TCW = $clog2(OVERSAMPLE);
   localparam logic [TCW-1:0] LAST_TICK = TCW'(OVERSAMPLE - 1);
   localparam logic [TCW-1:0] HALF_TICK = TCW'(OVERSAMPLE / 2 - 1);
   localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
   localparam logic           ODD_INV   = (PARITY == PAR_ODD);

   logic tick;

   uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) uTick (
      .CLK(CLK), .ARST_L(ARST_L), .TICK(tick)
   );

   txState_e             txState_q, txState_d;
   logic [DATA_BITS-1:0] txShift_q, txShift_d;
   logic [BCW-1:0]       txBit_q, txBit_d;
   logic [TCW-1:0]       txTick_q, txTick_d;
   logic                 txStop2_q, txStop2_d;
   logic                 txPar_q, txPar_d;
   logic                 txLine, txBitDone;

   always_comb begin
      txState_d = txState_q;
      txShift_d = txShift_q;
      txBit_d   = txBit_q;
      txTick_d  = txTick_q;
      txStop2_d = txStop2_q;
      txPar_d   = txPar_q;
      txLine    = 1'b1;
      txBitDone = tick && (txTick_q == LAST_TICK);
      if (tick) txTick_d = txBitDone ? '0 : txTick_q + 1'b1;
      case (txState_q)
         TX_IDLE: begin
            txTick_d = '0;
            if (bus.TX_VALID) begin
               txShift_d = bus.TX_DATA;
               txPar_d   = (^bus.TX_DATA) ^ ODD_INV;
               txBit_d   = '0;
               txStop2_d = 1'b0;
               txState_d = TX_START;
            end
         end
         TX_START: begin
            txLine = 1'b0;
            if (txBitDone) txState_d = TX_DATA;
         end
         TX_DATA: begin
            txLine = txShift_q[0];
            if (txBitDone) begin
               txShift_d = txShift_q >> 1;
               if (txBit_q == LAST_BIT) begin
                  txBit_d   = '0;
                  txState_d = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
               end else begin
                  txBit_d = txBit_q + 1'b1;
               end
            end
         end
         TX_PARITY: begin
            txLine = txPar_q;
            if (txBitDone) txState_d = TX_STOP;
         end
         TX_STOP: begin
            // The second stop bit reuses the per-bit tick counter for another lap.
            if (txBitDone) begin
               if ((STOP_BITS == 2) && !txStop2_q) txStop2_d = 1'b1;
               else                                txState_d = TX_IDLE;
            end
         end
         default: txState_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         txState_q <= TX_IDLE;
         txShift_q <= '0;
         txBit_q   <= '0;
         txTick_q  <= '0;
         txStop2_q <= 1'b0;
         txPar_q   <= 1'b0;
      end else begin
         txState_q <= txState_d;
         txShift_q <= txShift_d;
         txBit_q   <= txBit_d;
         txTick_q  <= txTick_d;
         txStop2_q <= txStop2_d;
         txPar_q   <= txPar_d;
      end
   end

   assign TX           = txLine;
   assign bus.TX_READY = (txState_q == TX_IDLE);

   logic rxMeta_q, rxSync_q, rxPrev_q;

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         rxMeta_q <= 1'b1;
         rxSync_q <= 1'b1;
         rxPrev_q <= 1'b1;
      end else begin
         rxMeta_q <= RX;
         rxSync_q <= rxMeta_q;
         rxPrev_q <= rxSync_q;
      end
   end

   rxState_e             rxState_q, rxState_d;
   logic [DATA_BITS-1:0] rxShift_q, rxShift_d;
   logic [BCW-1:0]       rxBit_q, rxBit_d;
   logic [TCW-1:0]       rxTick_q, rxTick_d;
   logic                 rxParErr_q, rxParErr_d;
   logic                 rxBitDone, rxDone, rxFerrNow;

   always_comb begin
      rxState_d  = rxState_q;
      rxShift_d  = rxShift_q;
      rxBit_d    = rxBit_q;
      rxTick_d   = rxTick_q;
      rxParErr_d = rxParErr_q;
      rxDone     = 1'b0;
      rxFerrNow  = 1'b0;
      rxBitDone  = tick && (rxTick_q == LAST_TICK);
      if (tick) rxTick_d = rxBitDone ? '0 : rxTick_q + 1'b1;
      case (rxState_q)
         RX_IDLE: begin
            rxTick_d   = '0;
            rxBit_d    = '0;
            rxParErr_d = 1'b0;
            if (rxPrev_q && !rxSync_q) rxState_d = RX_START;
         end
         RX_START: begin
            // Half-bit check both rejects glitches and aligns later samples to bit centres.
            if (tick && (rxTick_q == HALF_TICK)) begin
               rxTick_d  = '0;
               rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rxBitDone) begin
               rxShift_d = {rxSync_q, rxShift_q[DATA_BITS-1:1]};
               if (rxBit_q == LAST_BIT) begin
                  rxBit_d   = '0;
                  rxState_d = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
               end else begin
                  rxBit_d = rxBit_q + 1'b1;
               end
            end
         end
         RX_PARITY: begin
            if (rxBitDone) begin
               rxParErr_d = rxSync_q ^ (^rxShift_q) ^ ODD_INV;
               rxState_d  = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rxBitDone) begin
               rxDone    = 1'b1;
               rxFerrNow = !rxSync_q;
               rxState_d = RX_IDLE;
            end
         end
         default: rxState_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         rxState_q  <= RX_IDLE;
         rxShift_q  <= '0;
         rxBit_q    <= '0;
         rxTick_q   <= '0;
         rxParErr_q <= 1'b0;
      end else begin
         rxState_q  <= rxState_d;
         rxShift_q  <= rxShift_d;
         rxBit_q    <= rxBit_d;
         rxTick_q   <= rxTick_d;
         rxParErr_q <= rxParErr_d;
      end
   end

   logic [DATA_BITS-1:0] rxData_q, rxData_d;
   logic                 rxValid_q, rxValid_d;
   logic                 rxPerr_q, rxPerr_d;
   logic                 rxFerr_q, rxFerr_d;
   logic                 rxOvr_q, rxOvr_d;
   logic                 rxHs;

   // A consumer read on the completion cycle frees the holding slot, so it wins over overrun.
   always_comb begin
      rxData_d  = rxData_q;
      rxValid_d = rxValid_q;
      rxPerr_d  = rxPerr_q;
      rxFerr_d  = rxFerr_q;
      rxOvr_d   = rxOvr_q;
      rxHs      = rxValid_q && bus.RX_READY;
      if (rxDone && (!rxValid_q || rxHs)) begin
         rxData_d  = rxShift_q;
         rxPerr_d  = rxParErr_q;
         rxFerr_d  = rxFerrNow;
         rxValid_d = 1'b1;
      end else if (rxHs) begin
         rxValid_d = 1'b0;
      end
      if (rxHs)                      rxOvr_d = 1'b0;
      else if (rxDone && rxValid_q)  rxOvr_d = 1'b1;
   end

   always_ff @(posedge CLK or negedge ARST_L) begin
      if (!ARST_L) begin
         rxData_q  <= '0;
         rxValid_q <= 1'b0;
         rxPerr_q  <= 1'b0;
         rxFerr_q  <= 1'b0;
         rxOvr_q   <= 1'b0;
      end else begin
         rxData_q  <= rxData_d;
         rxValid_q <= rxValid_d;
         rxPerr_q  <= rxPerr_d;
         rxFerr_q  <= rxFerr_d;
         rxOvr_q   <= rxOvr_d;
      end
   end

   assign bus.RX_DATA  = rxData_q;
   assign bus.RX_VALID = rxValid_q;
   assign bus.RX_PERR  = rxPerr_q;
   assign bus.RX_FERR  = rxFerr_q;
   assign bus.RX_OVR   = rxOvr_q;

endmodule

// File: tb/tb_uart_xcvr_param.sv
// Bench for uart_xcvr_param: three instances (8N1, 8O2 for TX, 8E1 for RX) checked
// against a frame-level model every cycle plus hand-computed literal expectations.
module tb_uart_xcvr_param;

   localparam int CLK_HZ  = 16000000;
   localparam int BAUD    = 1000000;
   localparam int OVS     = 16;
   localparam int BIT_CYC = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic txN, txO, txE;
   logic rxIdle = 1'b1;
   logic rxLineE = 1'b1;

   int nCompared = 0;
   int nMismatched = 0;

   uart_xcvr_param_if #(.DATA_BITS(8)) busN ();
   uart_xcvr_param_if #(.DATA_BITS(8)) busO ();
   uart_xcvr_param_if #(.DATA_BITS(8)) busE ();

   uart_xcvr_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .OVERSAMPLE(OVS)) dutN (
      .CLK(clk), .ARST_L(rst_n), .RX(rxIdle), .TX(txN), .bus(busN));

   uart_xcvr_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2),
                     .STOP_BITS(2), .OVERSAMPLE(OVS)) dutO (
      .CLK(clk), .ARST_L(rst_n), .RX(rxIdle), .TX(txO), .bus(busO));

   uart_xcvr_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1),
                     .STOP_BITS(1), .OVERSAMPLE(OVS)) dutE (
      .CLK(clk), .ARST_L(rst_n), .RX(rxLineE), .TX(txE), .bus(busE));

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame as it appears on the wire, bit 0 first: start, data LSB first, parity, stops.
   function automatic logic [15:0] frameBits(input logic [7:0] d, input int par, input int stops);
      logic [15:0] b;
      int n;
      int ones;
      b = '1;
      n = 0;
      ones = 0;
      b[n] = 1'b0;
      n++;
      for (int i = 0; i < 8; i++) begin
         b[n] = d[i];
         ones += int'(d[i]);
         n++;
      end
      if (par != 0) b[n] = ((ones % 2) == 1) ^ (par == 2);
      return b;
   endfunction

   function automatic int frameLen(input int par, input int stops);
      return 1 + 8 + ((par != 0) ? 1 : 0) + stops;
   endfunction

   int          mBusy [2];
   int          mPos  [2];
   logic [15:0] mBits [2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy[0] <= 0;
         mPos[0]  <= 0;
      end else if (mBusy[0] > 0) begin
         mBusy[0] <= mBusy[0] - 1;
         mPos[0]  <= mPos[0] + 1;
      end else if (busN.TX_VALID === 1'b1) begin
         mBits[0] <= frameBits(busN.TX_DATA, 0, 1);
         mBusy[0] <= BIT_CYC * frameLen(0, 1);
         mPos[0]  <= 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mBusy[1] <= 0;
         mPos[1]  <= 0;
      end else if (mBusy[1] > 0) begin
         mBusy[1] <= mBusy[1] - 1;
         mPos[1]  <= mPos[1] + 1;
      end else if (busO.TX_VALID === 1'b1) begin
         mBits[1] <= frameBits(busO.TX_DATA, 2, 2);
         mBusy[1] <= BIT_CYC * frameLen(2, 2);
         mPos[1]  <= 0;
      end
   end

   function automatic logic expTx(input int k);
      return (mBusy[k] > 0) ? mBits[k][mPos[k] / BIT_CYC] : 1'b1;
   endfunction

   // Receive-side model: a one-word holding slot with a sticky overrun flag.
   logic       rxCheckEn = 1'b1;
   logic       mRxValid = 1'b0;
   logic [7:0] mRxData = 8'h00;
   logic       mRxPerr = 1'b0;
   logic       mRxFerr = 1'b0;
   logic       mRxOvr = 1'b0;

   task automatic modelFrame(input logic [7:0] d, input logic perr, input logic ferr);
      if (!mRxValid) begin
         mRxData  = d;
         mRxPerr  = perr;
         mRxFerr  = ferr;
         mRxValid = 1'b1;
      end else begin
         mRxOvr = 1'b1;
      end
   endtask

   task automatic modelRxReset();
      mRxValid = 1'b0;
      mRxData  = 8'h00;
      mRxPerr  = 1'b0;
      mRxFerr  = 1'b0;
      mRxOvr   = 1'b0;
   endtask

   always @(negedge clk) begin
      checkOutput("txN", {31'b0, txN}, {31'b0, expTx(0)});
      checkOutput("readyN", {31'b0, busN.TX_READY}, {31'b0, mBusy[0] == 0});
      checkOutput("txO", {31'b0, txO}, {31'b0, expTx(1)});
      checkOutput("readyO", {31'b0, busO.TX_READY}, {31'b0, mBusy[1] == 0});
      checkOutput("txE", {31'b0, txE}, 32'd1);
      checkOutput("readyE", {31'b0, busE.TX_READY}, 32'd1);
      if (rxCheckEn) begin
         checkOutput("rxValid", {31'b0, busE.RX_VALID}, {31'b0, mRxValid});
         checkOutput("rxData", {24'b0, busE.RX_DATA}, {24'b0, mRxData});
         checkOutput("rxPerr", {31'b0, busE.RX_PERR}, {31'b0, mRxPerr});
         checkOutput("rxFerr", {31'b0, busE.RX_FERR}, {31'b0, mRxFerr});
         checkOutput("rxOvr", {31'b0, busE.RX_OVR}, {31'b0, mRxOvr});
      end
   end

   // Drive one even-parity frame on the RX pin, optionally corrupting parity or stop.
   task automatic applyStimulusRxFrame(input logic [7:0] d, input logic flipPar, input logic stopLow);
      logic [10:0] bits;
      bits = {~stopLow, (^d) ^ flipPar, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         if (i == 10) rxCheckEn = 1'b0;
         rxLineE = bits[i];
         repeat (BIT_CYC) @(negedge clk);
      end
      rxLineE = 1'b1;
      modelFrame(d, flipPar, stopLow);
      rxCheckEn = 1'b1;
      repeat (20) @(negedge clk);
   endtask

   task automatic applyStimulusRxRead();
      rxCheckEn = 1'b0;
      busE.RX_READY = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busE.RX_READY = 1'b0;
      mRxValid = 1'b0;
      mRxOvr   = 1'b0;
      rxCheckEn = 1'b1;
   endtask

   task automatic applyStimulusTxA5();
      logic [9:0] expA5;
      logic       cen [0:15];
      int         k;
      int         lowCnt;
      expA5 = 10'b1_1010_0101_0;
      lowCnt = 0;
      k = 1;
      @(negedge clk);
      busN.TX_DATA = 8'hA5;
      busN.TX_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busN.TX_VALID = 1'b0;
      while (busN.TX_READY == 1'b0 && k < 400) begin
         if (k % BIT_CYC == 8) cen[k / BIT_CYC] = txN;
         lowCnt++;
         k++;
         @(negedge clk);
      end
      checkOutput("A5readyLowCycles", lowCnt, 160);
      for (int i = 0; i < 10; i++)
         checkOutput($sformatf("A5bit%0d", i), {31'b0, cen[i]}, {31'b0, expA5[i]});
      repeat (5) @(negedge clk);
   endtask

   task automatic applyStimulusTxO2();
      logic [11:0] expO;
      logic        cen [0:15];
      int          k;
      int          lowCnt;
      expO = 12'b11_1_0000_0011_0;
      lowCnt = 0;
      k = 1;
      @(negedge clk);
      busO.TX_DATA = 8'h03;
      busO.TX_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busO.TX_DATA = 8'h81;
      while (busO.TX_READY == 1'b0 && k < 400) begin
         if (k % BIT_CYC == 8) cen[k / BIT_CYC] = txO;
         lowCnt++;
         k++;
         @(negedge clk);
      end
      checkOutput("O2readyLowCycles", lowCnt, 192);
      for (int i = 0; i < 12; i++)
         checkOutput($sformatf("O2bit%0d", i), {31'b0, cen[i]}, {31'b0, expO[i]});
      checkOutput("O2readyBetween", {31'b0, busO.TX_READY}, 32'd1);
      @(negedge clk);
      checkOutput("O2backToBackStart", {31'b0, txO}, 32'd0);
      busO.TX_VALID = 1'b0;
      k = 0;
      while (busO.TX_READY == 1'b0 && k < 400) begin
         k++;
         @(negedge clk);
      end
      checkOutput("O2secondDone", {31'b0, busO.TX_READY}, 32'd1);
      repeat (5) @(negedge clk);
   endtask

   task automatic applyStimulusRx();
      applyStimulusRxFrame(8'h5A, 1'b0, 1'b0);
      checkOutput("E1goodValid", {31'b0, busE.RX_VALID}, 32'd1);
      checkOutput("E1goodData", {24'b0, busE.RX_DATA}, 32'h5A);
      checkOutput("E1goodPerr", {31'b0, busE.RX_PERR}, 32'd0);
      checkOutput("E1goodFerr", {31'b0, busE.RX_FERR}, 32'd0);
      applyStimulusRxRead();
      applyStimulusRxFrame(8'h5A, 1'b1, 1'b0);
      checkOutput("E1badParPerr", {31'b0, busE.RX_PERR}, 32'd1);
      applyStimulusRxRead();
      applyStimulusRxFrame(8'hC3, 1'b0, 1'b1);
      checkOutput("E1stopLowFerr", {31'b0, busE.RX_FERR}, 32'd1);
      checkOutput("E1stopLowData", {24'b0, busE.RX_DATA}, 32'hC3);
      applyStimulusRxRead();
      rxLineE = 1'b0;
      repeat (5) @(negedge clk);
      rxLineE = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("glitchNoValid", {31'b0, busE.RX_VALID}, 32'd0);
      applyStimulusRxFrame(8'h11, 1'b0, 1'b0);
      applyStimulusRxFrame(8'h22, 1'b0, 1'b0);
      checkOutput("ovrHeldData", {24'b0, busE.RX_DATA}, 32'h11);
      checkOutput("ovrFlag", {31'b0, busE.RX_OVR}, 32'd1);
      checkOutput("ovrValid", {31'b0, busE.RX_VALID}, 32'd1);
      applyStimulusRxRead();
      checkOutput("readClearsValid", {31'b0, busE.RX_VALID}, 32'd0);
      checkOutput("readClearsOvr", {31'b0, busE.RX_OVR}, 32'd0);
   endtask

   task automatic applyStimulusReset();
      @(negedge clk);
      busN.TX_DATA = 8'h96;
      busN.TX_VALID = 1'b1;
      @(posedge clk);
      @(negedge clk);
      busN.TX_VALID = 1'b0;
      repeat (30) @(negedge clk);
      rxLineE = 1'b0;
      repeat (BIT_CYC) @(negedge clk);
      rxLineE = 1'b1;
      repeat (BIT_CYC) @(negedge clk);
      rxLineE = 1'b0;
      repeat (5) @(negedge clk);
      checkOutput("midFrameReadyLow", {31'b0, busN.TX_READY}, 32'd0);
      #2;
      rst_n = 1'b0;
      modelRxReset();
      #1;
      checkOutput("rstImmediateTx", {31'b0, txN}, 32'd1);
      checkOutput("rstImmediateReady", {31'b0, busN.TX_READY}, 32'd1);
      checkOutput("rstImmediateRxValid", {31'b0, busE.RX_VALID}, 32'd0);
      rxLineE = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("postRstNoValid", {31'b0, busE.RX_VALID}, 32'd0);
      applyStimulusRxFrame(8'h3C, 1'b0, 1'b0);
      checkOutput("postRstValid", {31'b0, busE.RX_VALID}, 32'd1);
      checkOutput("postRstData", {24'b0, busE.RX_DATA}, 32'h3C);
      checkOutput("postRstPerr", {31'b0, busE.RX_PERR}, 32'd0);
      checkOutput("postRstFerr", {31'b0, busE.RX_FERR}, 32'd0);
      applyStimulusRxRead();
   endtask

   initial begin
      busN.TX_DATA = 8'h00; busN.TX_VALID = 1'b0; busN.RX_READY = 1'b0;
      busO.TX_DATA = 8'h00; busO.TX_VALID = 1'b0; busO.RX_READY = 1'b0;
      busE.TX_DATA = 8'h00; busE.TX_VALID = 1'b0; busE.RX_READY = 1'b0;
      #1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("resetTx", {31'b0, txN}, 32'd1);
      checkOutput("resetReady", {31'b0, busN.TX_READY}, 32'd1);
      checkOutput("resetRxValid", {31'b0, busE.RX_VALID}, 32'd0);
      checkOutput("resetRxData", {24'b0, busE.RX_DATA}, 32'd0);
      checkOutput("resetFlags", {29'b0, busE.RX_PERR, busE.RX_FERR, busE.RX_OVR}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      applyStimulusTxA5();
      applyStimulusTxO2();
      applyStimulusRx();
      applyStimulusReset();
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/uart_xcvr_param.md
Name: uart_xcvr_param

Overview:
- Parametrised full-duplex UART transceiver. It is the next-generation replacement for the fixed 8-bit RX/TX pair and its two-divider clocking scheme.
- Runs entirely on one system clock. An internal oversampling tick enable replaces the derived clocks.
- Adds configurable data width, parity, stop bits and oversampling; valid/ready handshakes on both data paths; parity, framing and overrun error reporting.
- Sits between the board RX/TX pins and the control/master logic.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- DATA_BITS, 8, payload width, legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits transmitted, 1 or 2. RX checks only the first stop bit.
- OVERSAMPLE, 16, ticks per bit, even, minimum 8.

Ports:
- CLK  in  1  system clock, rising edge.
- ARST_L  in  1  asynchronous active-low reset.
- RX  in  1  serial input, asynchronous to CLK.
- TX  out  1  serial output, idles high.
- TX_DATA  in  DATA_BITS  word to transmit.
- TX_VALID  in  1  TX_DATA is valid.
- TX_READY  out  1  transmitter can accept a word.
- RX_DATA  out  DATA_BITS  last received word.
- RX_VALID  out  1  RX_DATA and the error flags are valid.
- RX_READY  in  1  consumer accepts RX_DATA.
- RX_PERR  out  1  parity error on the held word. Always 0 when PARITY = 0.
- RX_FERR  out  1  framing error (stop bit sampled low) on the held word.
- RX_OVR  out  1  sticky overrun flag.

Behaviour:
- Reset (ARST_L low, effective immediately, asynchronous):
  - TX = 1, TX_READY = 1, RX_VALID = 0, RX_DATA = 0, all error flags = 0.
  - Both FSMs go to IDLE and the tick counter clears.
  - Reset mid-frame aborts the frame with no partial output.
- Tick generator:
  - DIV = round(CLK_HZ / (BAUD * OVERSAMPLE)), minimum 1.
  - Free-running counter 0..DIV-1; tick is a 1-cycle enable when the counter reaches DIV-1.
  - RX and TX share the tick.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Handshake occurs on a CLK edge where TX_VALID and TX_READY are both high. TX_DATA is latched and TX_READY drops on the next cycle.
  - TX goes low (START) on the cycle after the handshake.
  - Each bit state lasts OVERSAMPLE ticks, so the first bit may be short by at most DIV-1 cycles.
  - Data is sent LSB first. PARITY is skipped when PARITY = 0.
  - Parity bit: even mode = XOR of the data bits; odd mode = its inverse.
  - STOP holds TX high for STOP_BITS * OVERSAMPLE ticks.
  - TX_READY returns high on the cycle after the last stop tick, so back-to-back words have no extra idle time.
  - TX_VALID is ignored while TX_READY is low.
- RX path:
  - Two-flop synchroniser on RX; the FSM sees RX with 2-cycle latency.
  - IDLE: a synchronised high-to-low transition enters START.
  - START: after OVERSAMPLE/2 ticks, resample. Low → DATA; high → false start, return to IDLE with no output.
  - DATA: sample every OVERSAMPLE ticks (bit centre) and shift LSB first into the shift register.
  - PARITY (when enabled): one sample; mismatch sets the internal perr.
  - STOP: one sample; low sets ferr.
- RX frame completion (at the stop-bit centre tick):
  - If RX_VALID = 0: load RX_DATA, RX_PERR and RX_FERR, and set RX_VALID on the next cycle.
  - If RX_VALID = 1 (consumer has not read the held word): keep the held word, drop the new one, and set RX_OVR.
  - RX_OVR clears only on an RX_VALID & RX_READY handshake.
- RX handshake and re-arm:
  - RX_VALID & RX_READY on an edge clears RX_VALID on the next cycle. Flags remain with RX_DATA until replaced.
  - A handshake and a frame completion on the same cycle: the handshake wins, the new word loads, RX_VALID stays high, and there is no overrun.
  - After the stop-bit sample the FSM returns to IDLE immediately. A line held low (break) produces ferr frames repeatedly only after the line returns high, because IDLE requires a falling edge.
- Width rules:
  - Bit counter is clog2(DATA_BITS+1) bits wide.
  - Tick counter within a bit is clog2(OVERSAMPLE) bits wide; the two-stop-bit case counts twice.

Decomposition:
- Package uart_pkg:
  - parity mode constants PAR_NONE / PAR_EVEN / PAR_ODD;
  - TX and RX state enums;
  - a DIV calculation function.
- One sub-module, uart_baud_tick (parameters CLK_HZ, BAUD, OVERSAMPLE; ports CLK, ARST_L, TICK).
- TX and RX FSMs live in the top module.

Test Plan:
All scenarios use CLK_HZ = 16000000, BAUD = 1000000 and OVERSAMPLE = 16 unless stated, giving DIV = 1 and a 16-cycle bit.
1. TX 8N1, send 0xA5 → TX low for 16 cycles, then 1,0,1,0,0,1,0,1 at 16 cycles each, then high for 16. TX_READY is low for exactly 160 cycles.
2. TX with PARITY = 2 and STOP_BITS = 2, send 0x03 → parity bit 1, two stop bits, TX_READY low for 192 cycles. A second word queued on TX_VALID starts with no idle gap.
3. RX 8E1, drive 0x5A with correct parity → RX_VALID rises; RX_DATA = 0x5A, RX_PERR = 0, RX_FERR = 0. Repeat with the parity bit flipped → RX_PERR = 1.
4. RX with the stop bit driven low → RX_FERR = 1, RX_DATA = the received byte.
5. RX glitch low for 5 cycles → no RX_VALID and the FSM returns to IDLE. Two frames 0x11, 0x22 with RX_READY = 0 → RX_DATA = 0x11, RX_OVR = 1. Then pulse RX_READY → RX_VALID = 0, RX_OVR = 0.
6. Assert ARST_L low mid-TX and mid-RX → TX = 1 and TX_READY = 1 immediately. After release, no spurious RX_VALID, and a fresh 0x3C frame is received correctly.
